// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO write-side packer and read-side unpacker.
// An entry is laid out as {last, lanes-1, data}, with lane 0 in the LSBs of data.
// Contents: pack FSM state enum, entry geometry helpers, default-geometry field offsets.
package async_fifo_pkg;

  typedef enum logic {
    EMPTY   = 1'b0,  // no lanes accumulated, idx == 0
    PARTIAL = 1'b1   // 1 .. RATIO-1 lanes held in the accumulator
  } pack_state_e;

  // Total entry width for a given beat width and packing ratio.
  function automatic int entry_bits(input int in_bits, input int ratio);
    return 1 + $clog2(ratio) + in_bits * ratio;
  endfunction

  // LSB of the lane-count field (sits directly above the data lanes).
  function automatic int cnt_lsb(input int in_bits, input int ratio);
    return in_bits * ratio;
  endfunction

  // Position of the last flag (entry MSB).
  function automatic int last_bit(input int in_bits, input int ratio);
    return entry_bits(in_bits, ratio) - 1;
  endfunction

  // Field offsets for the default 8-bit x 4 geometry.
  localparam int DATA_LSB = 0;
  localparam int CNT_LSB  = cnt_lsb(8, 4);
  localparam int LAST_BIT = last_bit(8, 4);

endpackage

// File: rtl/async_fifo_wr_packer.sv
// Write-domain upsizer: packs RATIO narrow beats into one {last, lanes-1, data} FIFO entry.
// Ports: write_clk/write_rst_n; s_valid/s_ready/s_data/s_last beat stream in;
//        fifo_write_en/fifo_write_data/fifo_write_full FIFO write port; pkt_count, busy status.
module async_fifo_wr_packer
  import async_fifo_pkg::*;
#(
  parameter int IN_BITS = 8,
  parameter int RATIO   = 4
) (
  input  logic                                     write_clk,
  input  logic                                     write_rst_n,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [IN_BITS-1:0]                       s_data,
  input  logic                                     s_last,
  output logic                                     fifo_write_en,
  output logic [entry_bits(IN_BITS, RATIO)-1:0]    fifo_write_data,
  input  logic                                     fifo_write_full,
  output logic [15:0]                              pkt_count,
  output logic                                     busy
);

  localparam int CNT_BITS   = $clog2(RATIO);
  localparam int ENTRY_BITS = entry_bits(IN_BITS, RATIO);
  localparam int ACC_BITS   = IN_BITS * RATIO;
  localparam int LAST_POS   = last_bit(IN_BITS, RATIO);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(RATIO - 1);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("async_fifo_wr_packer: RATIO must be a power of two >= 2");
  end

  pack_state_e               state_q, state_d;
  logic [CNT_BITS-1:0]       idx_q, idx_d;
  logic [ACC_BITS-1:0]       acc_q, acc_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [ENTRY_BITS-1:0]     hold_data_q, hold_data_d;
  logic [15:0]               pkt_count_q, pkt_count_d;

  logic                      accept;
  logic                      completing;
  logic [ACC_BITS-1:0]       merged;

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state_q      <= EMPTY;
      idx_q        <= '0;
      acc_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    pkt_count_d  = pkt_count_q;

    fifo_write_en = hold_valid_q && !fifo_write_full;
    // Any blocked entry stalls the whole stream, so no beat can overtake it.
    s_ready       = !hold_valid_q || !fifo_write_full;
    accept        = s_valid && s_ready;
    completing    = accept && ((idx_q == LAST_IDX) || s_last);

    // Lanes at and above idx are still zero in acc, so this leaves unused lanes zero.
    merged = acc_q;
    merged[idx_q * IN_BITS +: IN_BITS] = s_data;

    if (fifo_write_en) begin
      hold_valid_d = 1'b0;
      if (hold_data_q[LAST_POS]) begin
        pkt_count_d = pkt_count_q + 16'd1;
      end
    end

    if (accept) begin
      if (completing) begin
        // Overrides the drain above, giving reload without a bubble.
        hold_valid_d = 1'b1;
        hold_data_d  = {s_last, idx_q, merged};
        acc_d        = '0;
        idx_d        = '0;
        state_d      = EMPTY;
      end else begin
        acc_d   = merged;
        idx_d   = idx_q + CNT_BITS'(1);
        state_d = PARTIAL;
      end
    end
  end

  assign fifo_write_data = hold_data_q;
  assign pkt_count       = pkt_count_q;
  assign busy            = (state_q == PARTIAL) || hold_valid_q;

endmodule

// File: tb/tb_async_fifo_wr_packer.sv
module tb_async_fifo_wr_packer;

  logic        write_clk;
  logic        write_rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        fifo_write_en;
  logic [34:0] fifo_write_data;
  logic        fifo_write_full;
  logic [15:0] pkt_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;

  logic [34:0] wr_data[$];
  int          wr_cyc[$];
  logic [15:0] wr_pkt[$];

  async_fifo_wr_packer #(.IN_BITS(8), .RATIO(4)) dut (
    .write_clk       (write_clk),
    .write_rst_n     (write_rst_n),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_last          (s_last),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .fifo_write_full (fifo_write_full),
    .pkt_count       (pkt_count),
    .busy            (busy)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  always @(posedge write_clk) cyc <= cyc + 1;

  // Log every write; wr_cyc is the edge that commits it.
  always @(negedge write_clk) begin
    if (fifo_write_en === 1'b1) begin
      wr_data.push_back(fifo_write_data);
      wr_cyc.push_back(cyc + 1);
      wr_pkt.push_back(pkt_count);
    end
  end

  function automatic logic [34:0] ent(input logic l, input logic [1:0] c, input logic [31:0] d);
    return {l, c, d};
  endfunction

  task automatic clear_log();
    wr_data.delete();
    wr_cyc.delete();
    wr_pkt.delete();
    stalls = 0;
  endtask

  task automatic do_reset();
    write_rst_n     = 1'b0;
    s_valid         = 1'b0;
    s_data          = 8'h00;
    s_last          = 1'b0;
    fifo_write_full = 1'b0;
    repeat (2) @(posedge write_clk);
    #1 write_rst_n = 1'b1;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [7:0] d, input logic l, output int acc_cyc);
    int budget;
    budget  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge write_clk);
      if (s_ready === 1'b1) begin
        @(posedge write_clk);
        #1;
        acc_cyc = cyc;
        break;
      end
      stalls++;
      budget++;
      if (budget > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: s_ready stuck at %b for beat %h, required 1", s_ready, d);
        acc_cyc = -1;
        break;
      end
      @(posedge write_clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge write_clk);
    #1;
  endtask

  task automatic test_reset();
    write_rst_n     = 1'b0;
    s_valid         = 1'b0;
    s_data          = 8'h00;
    s_last          = 1'b0;
    fifo_write_full = 1'b0;
    @(negedge write_clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
    checks++;
    if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", fifo_write_en); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d, required 0", pkt_count); end
    checks++;
    if (fifo_write_data !== 35'd0) begin errors++; $display("FAIL reset_wr_data: got %h, required 0", fifo_write_data); end
    @(posedge write_clk);
    #1 write_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int a;
    logic [7:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) send_beat(beats[i], i == 3, a);
    idle(4);
    checks++;
    if (wr_data.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d writes, required 1", wr_data.size());
    end else begin
      checks++;
      if (wr_data[0] !== ent(1'b1, 2'd3, 32'h44332211)) begin
        errors++; $display("FAIL basic_data: got %h, required %h", wr_data[0], ent(1'b1, 2'd3, 32'h44332211));
      end
      checks++;
      if (wr_cyc[0] != a + 1) begin
        errors++; $display("FAIL basic_latency: write at edge %0d, required %0d", wr_cyc[0], a + 1);
      end
    end
    checks++;
    if (pkt_count !== 16'd1) begin errors++; $display("FAIL basic_pkt_count: got %0d, required 1", pkt_count); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b, required 0", busy); end
  endtask

  task automatic test_short();
    int a;
    do_reset();
    clear_log();
    send_beat(8'hAA, 1'b1, a);
    send_beat(8'hB1, 1'b0, a);
    send_beat(8'hB2, 1'b1, a);
    idle(4);
    checks++;
    if (wr_data.size() != 2) begin
      errors++; $display("FAIL short_count: got %0d writes, required 2", wr_data.size());
    end else begin
      checks++;
      if (wr_data[0] !== ent(1'b1, 2'd0, 32'h000000AA)) begin
        errors++; $display("FAIL short_entry0: got %h, required %h", wr_data[0], ent(1'b1, 2'd0, 32'h000000AA));
      end
      checks++;
      if (wr_data[1] !== ent(1'b1, 2'd1, 32'h0000B2B1)) begin
        errors++; $display("FAIL short_entry1: got %h, required %h", wr_data[1], ent(1'b1, 2'd1, 32'h0000B2B1));
      end
    end
    checks++;
    if (pkt_count !== 16'd2) begin errors++; $display("FAIL short_pkt_count: got %0d, required 2", pkt_count); end
  endtask

  task automatic test_long();
    int a;
    do_reset();
    clear_log();
    for (int i = 1; i <= 6; i++) send_beat(8'(i), i == 6, a);
    idle(4);
    checks++;
    if (wr_data.size() != 2) begin
      errors++; $display("FAIL long_count: got %0d writes, required 2", wr_data.size());
    end else begin
      checks++;
      if (wr_data[0] !== ent(1'b0, 2'd3, 32'h04030201)) begin
        errors++; $display("FAIL long_entry0: got %h, required %h", wr_data[0], ent(1'b0, 2'd3, 32'h04030201));
      end
      checks++;
      if (wr_data[1] !== ent(1'b1, 2'd1, 32'h00000605)) begin
        errors++; $display("FAIL long_entry1: got %h, required %h", wr_data[1], ent(1'b1, 2'd1, 32'h00000605));
      end
      checks++;
      if (wr_pkt[1] !== 16'd0) begin
        errors++; $display("FAIL long_pkt_mid: got %0d after non-last entry, required 0", wr_pkt[1]);
      end
    end
    checks++;
    if (pkt_count !== 16'd1) begin errors++; $display("FAIL long_pkt_count: got %0d, required 1", pkt_count); end
  endtask

  task automatic test_backpressure();
    int a;
    logic [34:0] exp0;
    exp0 = ent(1'b1, 2'd3, 32'h54535251);
    do_reset();
    clear_log();
    for (int i = 1; i <= 4; i++) send_beat(8'h50 + 8'(i), i == 4, a);
    // hold_valid has just risen; block the FIFO with the next beat pending.
    fifo_write_full = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h61;
    s_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge write_clk);
      checks++;
      if (s_ready !== 1'b0 || fifo_write_en !== 1'b0 || fifo_write_data !== exp0) begin
        errors++;
        $display("FAIL bp_stall_cycle%0d: s_ready=%b wr_en=%b data=%h, required 0 0 %h",
                 k, s_ready, fifo_write_en, fifo_write_data, exp0);
      end
      @(posedge write_clk);
      #1;
    end
    fifo_write_full = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(8'h60 + 8'(i), i == 4, a);
    idle(4);
    checks++;
    if (wr_data.size() != 2) begin
      errors++; $display("FAIL bp_count: got %0d writes, required 2", wr_data.size());
    end else begin
      checks++;
      if (wr_data[0] !== exp0) begin
        errors++; $display("FAIL bp_entry0: got %h, required %h", wr_data[0], exp0);
      end
      checks++;
      if (wr_data[1] !== ent(1'b1, 2'd3, 32'h64636261)) begin
        errors++; $display("FAIL bp_entry1: got %h, required %h", wr_data[1], ent(1'b1, 2'd3, 32'h64636261));
      end
    end
    checks++;
    if (pkt_count !== 16'd2) begin errors++; $display("FAIL bp_pkt_count: got %0d, required 2", pkt_count); end
  endtask

  task automatic test_back_to_back();
    int a;
    logic [7:0]  b;
    logic [31:0] exp_d;
    do_reset();
    clear_log();
    for (int i = 0; i < 32; i++) send_beat(8'(i * 7 + 3), (i % 4) == 3, a);
    idle(4);
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d stall cycles, required 0", stalls); end
    checks++;
    if (wr_data.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d writes, required 8", wr_data.size());
    end else begin
      for (int e = 0; e < 8; e++) begin
        exp_d = '0;
        for (int l = 0; l < 4; l++) begin
          b = 8'((e * 4 + l) * 7 + 3);
          exp_d[l * 8 +: 8] = b;
        end
        checks++;
        if (wr_data[e] !== ent(1'b1, 2'd3, exp_d)) begin
          errors++; $display("FAIL b2b_entry%0d: got %h, required %h", e, wr_data[e], ent(1'b1, 2'd3, exp_d));
        end
        if (e > 0) begin
          checks++;
          if (wr_cyc[e] - wr_cyc[e-1] != 4) begin
            errors++; $display("FAIL b2b_spacing%0d: got %0d cycles, required 4", e, wr_cyc[e] - wr_cyc[e-1]);
          end
        end
      end
    end
    checks++;
    if (pkt_count !== 16'd8) begin errors++; $display("FAIL b2b_pkt_count: got %0d, required 8", pkt_count); end
  endtask

  task automatic test_reset_mid();
    int a;
    do_reset();
    clear_log();
    send_beat(8'h01, 1'b0, a);
    send_beat(8'h02, 1'b0, a);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b, required 1", busy); end
    write_rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge write_clk);
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b1 || fifo_write_en !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_in_reset%0d: busy=%b s_ready=%b wr_en=%b, required 0 1 0",
                 k, busy, s_ready, fifo_write_en);
      end
      @(posedge write_clk);
      #1;
    end
    write_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'h0A + 8'(i), i == 3, a);
    idle(4);
    checks++;
    if (wr_data.size() != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d writes, required 1", wr_data.size());
    end else begin
      checks++;
      if (wr_data[0] !== ent(1'b1, 2'd3, 32'h0D0C0B0A)) begin
        errors++; $display("FAIL rstmid_entry: got %h, required %h", wr_data[0], ent(1'b1, 2'd3, 32'h0D0C0B0A));
      end
    end
    checks++;
    if (pkt_count !== 16'd1) begin errors++; $display("FAIL rstmid_pkt_count: got %0d, required 1", pkt_count); end
  endtask

  initial begin
    write_rst_n     = 1'b0;
    s_valid         = 1'b0;
    s_data          = 8'h00;
    s_last          = 1'b0;
    fifo_write_full = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
